skid_buffer: RTL and testbench
==============================

SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width per channel in bits (>=1).
REQ-002 SHALL have parameter NUM_CH, default 1, number of independent channels (1..16).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_flush  input  1  synchronous flush of all channels.
REQ-006 SHALL have port i_valid  input  NUM_CH  per-channel upstream valid.
REQ-007 SHALL have port i_din  input  NUM_CH*DATA_W  per-channel payload, channel c at bits [c*DATA_W +: DATA_W].
REQ-008 SHALL have port o_ready  output  NUM_CH  per-channel upstream ready.
REQ-009 SHALL have port o_valid  output  NUM_CH  per-channel downstream valid.
REQ-010 SHALL have port o_dout  output  NUM_CH*DATA_W  per-channel payload, same packing as i_din.
REQ-011 SHALL have port i_ready  input  NUM_CH  per-channel downstream ready.
REQ-012 SHALL have port o_full  output  NUM_CH  per-channel status, high when both entries are occupied.

Function
REQ-013 SHALL treat a transfer as valid&ready high on the same rising edge, on each side independently per channel.
REQ-014 SHALL hold per channel an output register (OUT) and a skid register (SKID), plus a 2-bit state: EMPTY, ONE, FULL.
REQ-015 SHALL drive o_valid, o_dout, o_ready and o_full only from registers; no combinational path from i_ready or i_valid to any output.
REQ-016 SHALL drive o_ready=1 in EMPTY and ONE, 0 in FULL; o_valid=1 in ONE and FULL; o_full=1 only in FULL.
REQ-017 SHALL, in EMPTY with i_valid, load OUT<=i_din and go to ONE.
REQ-018 SHALL, in ONE with i_valid and i_ready, load OUT<=i_din and stay in ONE.
REQ-019 SHALL, in ONE with i_valid and !i_ready, load SKID<=i_din and go to FULL; OUT is unchanged.
REQ-020 SHALL, in ONE with !i_valid and i_ready, go to EMPTY.
REQ-021 SHALL, in FULL with i_ready, load OUT<=SKID and go to ONE; i_valid is ignored in FULL.
REQ-022 SHALL hold OUT, SKID and state in all other cases, with o_dout stable while o_valid && !i_ready.
REQ-023 SHALL give one-cycle latency, i_din accepted at edge N appearing on o_dout after edge N.
REQ-024 SHALL sustain one transfer per cycle per channel when i_ready is held high.
REQ-025 SHALL deliver data in acceptance order per channel, with no loss and no duplication.
REQ-026 SHALL, on i_flush=1 at an edge, set all channels to EMPTY regardless of i_valid/i_ready; the input offered that cycle is discarded and data regs are unchanged.
REQ-027 SHALL keep channels fully independent, so a stall on channel c never affects channel d.

Reset
REQ-028 SHALL, on i_reset_n low, asynchronously set every channel to EMPTY: o_valid=0, o_full=0, o_ready=1, OUT=0, SKID=0.
REQ-029 SHALL take no transfer on the first edge after i_reset_n deasserts unless i_valid is high; reset mid-FULL loses both entries by design.

Structure
REQ-030 SHALL take the state enum type skid_state_t (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) from shared package skids_pkg; the unused encoding 2'd3 SHALL be recovered to EMPTY.
REQ-031 SHALL implement one channel as sub-module skid_slot (params DATA_W), instantiated NUM_CH times via generate; skid_buffer only slices buses and fans out i_flush and reset.

Verification
REQ-032 SHALL cover stream: i_ready=1, i_valid=1, din 1,2,3,4 on ch0 -> o_dout 1,2,3,4 on consecutive cycles, each one cycle after acceptance, o_ready stays 1.
REQ-033 SHALL cover stall: send 0xA, 0xB with i_ready=0 -> FULL, o_ready=0, o_dout=0xA held; raise i_ready -> 0xA then 0xB, then EMPTY.
REQ-034 SHALL cover offer in FULL: i_valid=1 with din 0xC while FULL -> 0xC is not accepted and never appears at o_dout.
REQ-035 SHALL cover flush: FULL with 0xA/0xB plus i_flush=1 and i_valid=1 with din 0xD -> next cycle o_valid=0, o_ready=1; no 0xA, 0xB or 0xD is output.
REQ-036 SHALL cover async reset: i_reset_n low mid-clock in FULL -> o_valid=0, o_full=0, o_ready=1 before the next edge.
REQ-037 SHALL cover channel independence: NUM_CH=4, ch2 i_ready=0, others streaming -> only ch2 reaches FULL; ch0/1/3 are uninterrupted.

Source files
------------

// File: rtl/skids_pkg.sv
// Shared types for the skid buffer.
// Slot state encoding and small helpers.
package skids_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Upstream may push while at most one entry is held.
    function automatic logic can_accept(input skid_state_t s);
        return (s == EMPTY) || (s == ONE);
    endfunction

    // Downstream sees data whenever OUT holds an entry.
    function automatic logic has_data(input skid_state_t s);
        return (s == ONE) || (s == FULL);
    endfunction

endpackage

// File: rtl/skid_buffer_if.sv
// Valid/ready stream bundle.
// W is payload width per lane, N the lane count.
interface skid_buffer_if #(
    parameter int W = 32,
    parameter int N = 1
);

    logic [N-1:0]   valid;
    logic [N-1:0]   ready;
    logic [N*W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/skid_slot.sv
// One channel of the skid buffer.
// Two-entry OUT/SKID store; all outputs come from flops.
module skid_slot
    import skids_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    skid_buffer_if.slave  s_if,
    skid_buffer_if.master m_if,
    output logic          full
);

    skid_state_t       state_q;
    skid_state_t       state_d;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] out_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;

    logic              in_v;
    logic              dn_r;
    logic [DATA_W-1:0] in_d;

    assign in_v = s_if.valid[0];
    assign in_d = s_if.data[DATA_W-1:0];
    assign dn_r = m_if.ready[0];

    // Next state and data moves; flush empties without touching data.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_v) begin
                    out_d   = in_d;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_v && dn_r) begin
                    out_d = in_d;
                end else if (in_v) begin
                    skid_d  = in_d;
                    state_d = FULL;
                end else if (dn_r) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (dn_r) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (flush) begin
            state_d = EMPTY;
            out_d   = out_q;
            skid_d  = skid_q;
        end
    end

    // State and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign s_if.ready = can_accept(state_q);
    assign m_if.valid = has_data(state_q);
    assign m_if.data  = out_q;
    assign full       = (state_q == FULL);

endmodule

// File: rtl/skid_buffer.sv
// Multi-channel registered skid buffer.
// Slices the packed buses into independent skid_slot channels.
module skid_buffer #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_flush,
    input  logic [NUM_CH-1:0]        i_valid,
    input  logic [NUM_CH*DATA_W-1:0] i_din,
    output logic [NUM_CH-1:0]        o_ready,
    output logic [NUM_CH-1:0]        o_valid,
    output logic [NUM_CH*DATA_W-1:0] o_dout,
    input  logic [NUM_CH-1:0]        i_ready,
    output logic [NUM_CH-1:0]        o_full
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

        skid_buffer_if #(.W(DATA_W), .N(1)) up_if ();
        skid_buffer_if #(.W(DATA_W), .N(1)) dn_if ();

        assign up_if.valid = i_valid[c];
        assign up_if.data  = i_din[c*DATA_W +: DATA_W];
        assign o_ready[c]  = up_if.ready[0];

        assign dn_if.ready = i_ready[c];
        assign o_valid[c]  = dn_if.valid[0];
        assign o_dout[c*DATA_W +: DATA_W] = dn_if.data;

        skid_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk   (i_clk),
            .rst_n (i_reset_n),
            .flush (i_flush),
            .s_if  (up_if.slave),
            .m_if  (dn_if.master),
            .full  (o_full[c])
        );

    end

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer.
// Reference model: a 2-deep FIFO queue per channel.
module tb_skid_buffer;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic           flush;
    logic [N-1:0]   vld;
    logic [N*W-1:0] din;
    logic [N-1:0]   dn_rdy;
    logic [N-1:0]   o_ready;
    logic [N-1:0]   o_valid;
    logic [N*W-1:0] o_dout;
    logic [N-1:0]   o_full;

    skid_buffer_if #(.W(W), .N(N)) up_if ();
    skid_buffer_if #(.W(W), .N(N)) dn_if ();

    assign up_if.valid = vld;
    assign up_if.data  = din;
    assign up_if.ready = o_ready;
    assign dn_if.valid = o_valid;
    assign dn_if.data  = o_dout;
    assign dn_if.ready = dn_rdy;

    skid_buffer #(
        .DATA_W (W),
        .NUM_CH (N)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_flush   (flush),
        .i_valid   (up_if.valid),
        .i_din     (up_if.data),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .o_dout    (o_dout),
        .i_ready   (dn_if.ready),
        .o_full    (o_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] mq[N][$];

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] dout(input int c);
        return o_dout[c*W +: W];
    endfunction

    task automatic set_ch(input int c, input logic v,
                          input logic [W-1:0] d, input logic r);
        vld[c]         = v;
        din[c*W +: W]  = d;
        dn_rdy[c]      = r;
    endtask

    task automatic compare_all();
        for (int c = 0; c < N; c++) begin
            int sz;
            sz = mq[c].size();
            check($sformatf("ch%0d ready", c), 64'(o_ready[c]), 64'(sz < 2));
            check($sformatf("ch%0d valid", c), 64'(o_valid[c]), 64'(sz > 0));
            check($sformatf("ch%0d full", c), 64'(o_full[c]), 64'(sz == 2));
            if (sz > 0)
                check($sformatf("ch%0d dout", c), 64'(dout(c)),
                      64'(mq[c][0]));
        end
    endtask

    task automatic step();
        logic [N-1:0]   v;
        logic [N-1:0]   r;
        logic [N*W-1:0] d;
        logic           f;
        v = vld;
        r = dn_rdy;
        d = din;
        f = flush;
        @(posedge clk);
        for (int c = 0; c < N; c++) begin
            logic take_in;
            logic take_out;
            take_in  = v[c] && (mq[c].size() < 2);
            take_out = r[c] && (mq[c].size() > 0);
            if (f) begin
                mq[c].delete();
            end else begin
                if (take_out) void'(mq[c].pop_front());
                if (take_in) mq[c].push_back(d[c*W +: W]);
            end
        end
        #1;
        compare_all();
    endtask

    task automatic idle_all();
        for (int c = 0; c < N; c++) set_ch(c, 1'b0, '0, 1'b1);
        flush = 1'b0;
    endtask

    task automatic fill_ab();
        set_ch(0, 1'b1, 16'h000A, 1'b0);
        step();
        set_ch(0, 1'b1, 16'h000B, 1'b0);
        step();
    endtask

    initial begin
        rst_n  = 1'b0;
        flush  = 1'b0;
        vld    = '0;
        din    = '0;
        dn_rdy = '1;
        #12;
        check("rst ready", 64'(o_ready), 64'({N{1'b1}}));
        check("rst valid", 64'(o_valid), 64'(0));
        check("rst full", 64'(o_full), 64'(0));
        check("rst dout", 64'(o_dout), 64'(0));
        rst_n = 1'b1;
        #4;
        idle_all();
        step();

        // Streaming at full rate on ch0
        for (int i = 1; i <= 4; i++) begin
            set_ch(0, 1'b1, W'(i), 1'b1);
            step();
            check("stream dout", 64'(dout(0)), 64'(i));
            check("stream ready", 64'(o_ready[0]), 64'(1));
        end
        idle_all();
        step();

        // Stall, then offer in FULL, then drain
        fill_ab();
        check("stall full", 64'(o_full[0]), 64'(1));
        check("stall ready", 64'(o_ready[0]), 64'(0));
        check("stall dout", 64'(dout(0)), 64'(16'h000A));
        set_ch(0, 1'b1, 16'h000C, 1'b0);
        step();
        check("offer held", 64'(dout(0)), 64'(16'h000A));
        set_ch(0, 1'b0, '0, 1'b1);
        step();
        check("drain b", 64'(dout(0)), 64'(16'h000B));
        step();
        check("drain empty", 64'(o_valid[0]), 64'(0));

        // Flush while FULL with a new offer
        fill_ab();
        set_ch(0, 1'b1, 16'h000D, 1'b0);
        flush = 1'b1;
        step();
        check("flush valid", 64'(o_valid[0]), 64'(0));
        check("flush ready", 64'(o_ready[0]), 64'(1));
        idle_all();
        step();
        check("flush stays", 64'(o_valid[0]), 64'(0));

        // Async reset in FULL, mid-cycle
        fill_ab();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst valid", 64'(o_valid[0]), 64'(0));
        check("arst full", 64'(o_full[0]), 64'(0));
        check("arst ready", 64'(o_ready[0]), 64'(1));
        check("arst dout", 64'(dout(0)), 64'(0));
        for (int c = 0; c < N; c++) mq[c].delete();
        #1;
        rst_n = 1'b1;
        idle_all();
        step();

        // Channel independence: ch2 stalled, others stream
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < N; c++)
                set_ch(c, 1'b1, W'(16'h100 * c + k), c != 2);
            step();
        end
        check("indep ch2 full", 64'(o_full[2]), 64'(1));
        check("indep others", 64'({o_full[3], o_full[1], o_full[0]}),
              64'(0));
        check("indep ch3 dout", 64'(dout(3)), 64'(16'h0305));
        idle_all();
        step();
        step();

        // Randomized traffic
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < N; c++)
                set_ch(c, 1'($urandom_range(0, 3) != 0),
                       W'($urandom), 1'($urandom_range(0, 2) != 0));
            flush = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
